aes_round_stream: RTL and testbench

Streaming, parametrised successor of the two-stage AES encryption round. It performs one AES round per accepted beat: SubBytes, ShiftRows, optional MixColumns, then AddRoundKey. It adds valid/ready flow control with full backpressure, a per-beat round key and final-round flag carried through the pipe, a user tag, and a selectable pipeline depth. It sits between the round-key scheduler and the round-iteration controller of the encryption core, and can also be chained 10/12/14 deep for an unrolled core.

---
 rtl/aes_round_stream.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_aes_round_stream.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_stream.sv
// -----------------------------------------------------------------------------
// aes_round_stream
//
// One AES encryption round per accepted beat, with valid/ready flow control:
// SubBytes -> ShiftRows -> MixColumns (skipped on the final round) ->
// AddRoundKey. The round key, final-round flag and a user tag travel with
// each beat. SB_REG selects a 2-stage pipe (register after SubBytes) or a
// 1-stage pipe (SubBytes feeds the output register combinationally).
//
// Parameters
//   SB_REG     1 = register after SubBytes (latency 2), 0 = latency 1
//   TAG_W      width of the user tag
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   sys_en            global enable; low freezes all state and handshakes
//   in_valid/ready    input handshake
//   in_state/key      state before this round and its round key
//   in_last, in_tag   final-round flag and user tag of the beat
//   out_valid/ready   output handshake
//   out_state         round result
//   out_tag, out_last side fields of the beat on out_state
//
// Optional build macro AES_ROUND_STREAM_DBG_EN adds dbg_sb, dbg_sr and
// dbg_mc: the SubBytes/ShiftRows/MixColumns intermediates of the beat on
// out_state, held in the output stage.
//
// Also contains the combinational helpers aes_shiftrows, aes_mixcolumns and
// aes_addroundkey. Byte n of a state sits at [127-8n -: 8], column-major,
// so byte (row r, column c) is n = 4c + r.
// -----------------------------------------------------------------------------

// ShiftRows: row r rotates left by r columns.
module aes_shiftrows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    always_comb begin
        // NOTE: every output written in always_comb gets a default first so no latch is inferred.
        state_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                state_o[127 - 8*(4*c + r) -: 8] = state_i[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end
endmodule

// MixColumns: each column multiplied by the fixed circulant {02,03,01,01}.
module aes_mixcolumns (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = state_i[127 - 32*c -: 8];
        assign a1 = state_i[119 - 32*c -: 8];
        assign a2 = state_i[111 - 32*c -: 8];
        assign a3 = state_i[103 - 32*c -: 8];

        assign state_o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign state_o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign state_o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign state_o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

// AddRoundKey: plain XOR with the round key.
module aes_addroundkey (
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    output logic [127:0] state_o
);
    assign state_o = state_i ^ key_i;
endmodule

module aes_round_stream #(
    parameter int unsigned SB_REG = 1,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sys_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic [127:0]     in_key,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last
`ifdef AES_ROUND_STREAM_DBG_EN
    ,
    output logic [127:0]     dbg_sb,
    output logic [127:0]     dbg_sr,
    output logic [127:0]     dbg_mc
`endif
);

    // Forward S-box, byte 0x00 in the top byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives at bit offset 8*(255-b); 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Stage B (output register) control. It loads when empty or when its
    // beat is being taken this cycle; sys_en low blocks every load.
    // ---------------------------------------------------------------------
    logic             b_valid_q, b_valid_d;
    logic [127:0]     b_state_q, b_state_d;
    logic [TAG_W-1:0] b_tag_q,   b_tag_d;
    logic             b_last_q,  b_last_d;
    logic             b_load;

    assign b_load = sys_en & (~b_valid_q | out_ready);

    // Beat presented to stage B: either stage A's contents or the live input.
    logic             src_valid;
    logic [127:0]     src_sb;
    logic [127:0]     src_key;
    logic             src_last;
    logic [TAG_W-1:0] src_tag;

    if (SB_REG != 0) begin : g_stage_a
        logic             a_valid_q, a_valid_d;
        logic [127:0]     a_sb_q,    a_sb_d;
        logic [127:0]     a_key_q,   a_key_d;
        logic             a_last_q,  a_last_d;
        logic [TAG_W-1:0] a_tag_q,   a_tag_d;
        logic             a_load;

        // Stage A loads when empty or when its beat moves into stage B.
        // in_valid is not in this term, so in_ready never waits on it.
        assign a_load   = sys_en & (~a_valid_q | b_load);
        assign in_ready = rst_n & a_load;

        always_comb begin
            a_valid_d = a_valid_q;
            a_sb_d    = a_sb_q;
            a_key_d   = a_key_q;
            a_last_d  = a_last_q;
            a_tag_d   = a_tag_q;
            if (a_load) begin
                a_valid_d = in_valid;
                if (in_valid) begin
                    a_sb_d   = sub_bytes(in_state);
                    a_key_d  = in_key;
                    a_last_d = in_last;
                    a_tag_d  = in_tag;
                end
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (!rst_n) begin
                a_valid_q <= 1'b0;
            end else begin
                a_valid_q <= a_valid_d;
            end
        end

        // NOTE: stage-A payload has no reset; it is only ever consumed when a_valid_q is set.
        always_ff @(posedge clk) begin
            a_sb_q   <= a_sb_d;
            a_key_q  <= a_key_d;
            a_last_q <= a_last_d;
            a_tag_q  <= a_tag_d;
        end

        assign src_valid = a_valid_q;
        assign src_sb    = a_sb_q;
        assign src_key   = a_key_q;
        assign src_last  = a_last_q;
        assign src_tag   = a_tag_q;
    end else begin : g_no_stage_a
        assign in_ready  = rst_n & b_load;
        assign src_valid = in_valid;
        assign src_sb    = sub_bytes(in_state);
        assign src_key   = in_key;
        assign src_last  = in_last;
        assign src_tag   = in_tag;
    end

    // ---------------------------------------------------------------------
    // Round datapath after SubBytes.
    // ---------------------------------------------------------------------
    logic [127:0] sr_w;
    logic [127:0] mc_w;
    logic [127:0] mix_sel;
    logic [127:0] ark_w;

    aes_shiftrows u_shiftrows (
        .state_i (src_sb),
        .state_o (sr_w)
    );

    aes_mixcolumns u_mixcolumns (
        .state_i (sr_w),
        .state_o (mc_w)
    );

    // The final round skips MixColumns.
    assign mix_sel = src_last ? sr_w : mc_w;

    aes_addroundkey u_addroundkey (
        .state_i (mix_sel),
        .key_i   (src_key),
        .state_o (ark_w)
    );

    // ---------------------------------------------------------------------
    // Stage B registers. Payload only changes when a real beat loads, so
    // out_* stay put after a take with nothing behind it.
    // ---------------------------------------------------------------------
    always_comb begin
        b_valid_d = b_valid_q;
        b_state_d = b_state_q;
        b_tag_d   = b_tag_q;
        b_last_d  = b_last_q;
        if (b_load) begin
            b_valid_d = src_valid;
            if (src_valid) begin
                b_state_d = ark_w;
                b_tag_d   = src_tag;
                b_last_d  = src_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_valid_q <= 1'b0;
            b_state_q <= '0;
            b_tag_q   <= '0;
            b_last_q  <= 1'b0;
        end else begin
            b_valid_q <= b_valid_d;
            b_state_q <= b_state_d;
            b_tag_q   <= b_tag_d;
            b_last_q  <= b_last_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_state = b_state_q;
    assign out_tag   = b_tag_q;
    assign out_last  = b_last_q;

`ifdef AES_ROUND_STREAM_DBG_EN
    logic [127:0] dbg_sb_q, dbg_sb_d;
    logic [127:0] dbg_sr_q, dbg_sr_d;
    logic [127:0] dbg_mc_q, dbg_mc_d;

    always_comb begin
        dbg_sb_d = dbg_sb_q;
        dbg_sr_d = dbg_sr_q;
        dbg_mc_d = dbg_mc_q;
        if (b_load && src_valid) begin
            dbg_sb_d = src_sb;
            dbg_sr_d = sr_w;
            dbg_mc_d = mc_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbg_sb_q <= '0;
            dbg_sr_q <= '0;
            dbg_mc_q <= '0;
        end else begin
            dbg_sb_q <= dbg_sb_d;
            dbg_sr_q <= dbg_sr_d;
            dbg_mc_q <= dbg_mc_d;
        end
    end

    assign dbg_sb = dbg_sb_q;
    assign dbg_sr = dbg_sr_q;
    assign dbg_mc = dbg_mc_q;
`endif

endmodule

// File: tb/tb_aes_round_stream.sv
// -----------------------------------------------------------------------------
// Self-checking bench for aes_round_stream. Two instances share the inputs:
// u_dut (SB_REG=1) is the main target, u_dut_c (SB_REG=0) is checked for
// single-cycle latency on the directed vectors. Inputs are driven 1 time
// unit after the rising edge and outputs are sampled on the falling edge.
// The reference round model builds its S-box from the GF(2^8) inverse and
// affine map rather than from a copied table.
// -----------------------------------------------------------------------------
module tb_aes_round_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sys_en;
    logic         in_valid;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic [3:0]   in_tag;
    logic         out_ready;

    logic         in_ready,   in_ready_c;
    logic         out_valid,  out_valid_c;
    logic [127:0] out_state,  out_state_c;
    logic [3:0]   out_tag,    out_tag_c;
    logic         out_last,   out_last_c;

`ifdef AES_ROUND_STREAM_DBG_EN
    logic [127:0] dbg_sb, dbg_sr, dbg_mc;
    logic [127:0] dbg_sb_c, dbg_sr_c, dbg_mc_c;
`endif

    always #5 clk = ~clk;

    aes_round_stream #(.SB_REG(1), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sys_en    (sys_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_tag   (out_tag),
        .out_last  (out_last)
`ifdef AES_ROUND_STREAM_DBG_EN
        ,
        .dbg_sb    (dbg_sb),
        .dbg_sr    (dbg_sr),
        .dbg_mc    (dbg_mc)
`endif
    );

    aes_round_stream #(.SB_REG(0), .TAG_W(4)) u_dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .sys_en    (sys_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready_c),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid_c),
        .out_ready (out_ready),
        .out_state (out_state_c),
        .out_tag   (out_tag_c),
        .out_last  (out_last_c)
`ifdef AES_ROUND_STREAM_DBG_EN
        ,
        .dbg_sb    (dbg_sb_c),
        .dbg_sr    (dbg_sr_c),
        .dbg_mc    (dbg_mc_c)
`endif
    );

    // ---------------------------------------------------------------- checks
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ------------------------------------------------------- reference model
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [4][4];
        logic [7:0]   b [4][4];
        logic [7:0]   m [4][4];
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                a[rr][c] = sbox_tab[s[127 - 8*(4*c + rr) -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[rr][c] = a[rr][(c + rr) % 4];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                m[rr][c] = last ? b[rr][c]
                                : gmul(8'h02, b[rr][c]) ^ gmul(8'h03, b[(rr + 1) % 4][c])
                                  ^ b[(rr + 2) % 4][c] ^ b[(rr + 3) % 4][c];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                r[127 - 8*(4*c + rr) -: 8] = m[rr][c];
        return r ^ k;
    endfunction

    // ---------------------------------------------------------- vector table
    typedef struct packed {
        logic [127:0] st;
        logic [127:0] key;
        logic         last;
        logic [3:0]   tag;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [4];

    typedef struct packed {
        logic [127:0] st;
        logic [3:0]   tag;
        logic         last;
    } exp_t;

    exp_t         sb_q [$];
    exp_t         e;
    int           sent, recv, cycles;
    logic         hold;
    logic [127:0] h_state;
    logic [3:0]   h_tag;
    logic [127:0] s_fix;

    initial begin
        vecs[0] = '{st: 128'h193de3bea0f4e22b9ac68d2ae9f84808, key: 128'ha0fafe1788542cb123a339392a6c7605,
                    last: 1'b0, tag: 4'h3, exp: 128'ha49c7ff2689f352b6b5bea43026a5049};
        vecs[1] = '{st: 128'heb40f21e592e38848ba113e71bc342d2, key: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    last: 1'b1, tag: 4'ha, exp: 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{st: 128'h0, key: 128'h0, last: 1'b0, tag: 4'h5, exp: {16{8'h63}}};
        vecs[3] = '{st: 128'h0, key: {128{1'b1}}, last: 1'b1, tag: 4'hf, exp: {16{8'h9c}}};

        build_sbox();

        rst_n = 1'b0; sys_en = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0;
        in_last = 1'b0; in_tag = '0; out_ready = 1'b1;

        // ---- reset for 3+ cycles
        repeat (3) @(posedge clk);
        sample();
        check("rst_in_ready_low", in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        sample();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_state", out_state, 128'h0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_c_in_ready", in_ready_c, 1'b1);
        check("rst_c_out_valid", out_valid_c, 1'b0);

        // ---- table-driven single beats, both depths
        for (int v = 0; v < 4; v++) begin
            tick();
            in_valid = 1'b1; in_state = vecs[v].st; in_key = vecs[v].key;
            in_last = vecs[v].last; in_tag = vecs[v].tag; out_ready = 1'b1;
            sample();
            check("vec_in_ready", in_ready, 1'b1);
            check("vec_c_in_ready", in_ready_c, 1'b1);
            tick();
            in_valid = 1'b0;
            sample();
            check("vec_not_early", out_valid, 1'b0);
            check("vec_c_valid", out_valid_c, 1'b1);
            check("vec_c_state", out_state_c, vecs[v].exp);
            check("vec_c_tag", out_tag_c, vecs[v].tag);
            check("vec_c_last", out_last_c, vecs[v].last);
            tick();
            sample();
            check("vec_valid", out_valid, 1'b1);
            check("vec_state", out_state, vecs[v].exp);
            check("vec_tag", out_tag, vecs[v].tag);
            check("vec_last", out_last, vecs[v].last);
            check("vec_c_drained", out_valid_c, 1'b0);
        end

        // ---- back-to-back 8 beats, no bubbles
        s_fix = vecs[0].st;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (cyc < 8) begin
                in_valid = 1'b1; in_state = s_fix; in_key = {16{8'(cyc)}};
                in_last = 1'(cyc % 2); in_tag = 4'(cyc);
            end else begin
                in_valid = 1'b0;
            end
            sample();
            if (cyc < 8) check("b2b_in_ready", in_ready, 1'b1);
            check("b2b_out_valid", out_valid, (cyc >= 2 && cyc < 10));
            if (cyc >= 2 && cyc < 10) begin
                check("b2b_tag", out_tag, 4'(cyc - 2));
                check("b2b_state", out_state, ref_round(s_fix, {16{8'(cyc - 2)}}, 1'((cyc - 2) % 2)));
            end
        end

        // ---- stall with full pipe, refill in the cycle out_ready returns
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            in_valid = 1'b1; in_state = s_fix; in_key = {16{8'(8'h40 + i)}};
            in_last = 1'b0; in_tag = 4'(i);
            sample();
            check("stall_in_ready", in_ready, (i < 2));
        end
        check("stall_valid", out_valid, 1'b1);
        check("stall_tag", out_tag, 4'h0);
        tick();
        sample();
        check("stall2_in_ready", in_ready, 1'b0);
        check("stall2_state", out_state, ref_round(s_fix, {16{8'h40}}, 1'b0));
        tick();
        out_ready = 1'b1;
        sample();
        check("refill_in_ready", in_ready, 1'b1);
        check("refill_tag0", out_tag, 4'h0);
        tick();
        in_valid = 1'b0;
        sample();
        check("refill_tag1", out_tag, 4'h1);
        tick();
        sample();
        check("refill_tag2", out_tag, 4'h2);
        check("refill_state2", out_state, ref_round(s_fix, {16{8'h42}}, 1'b0));
        tick();
        sample();
        check("refill_empty", out_valid, 1'b0);

        // ---- sys_en freeze for 5 cycles mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            in_valid = 1'b1; in_state = s_fix; in_key = {16{8'(8'h80 + i)}};
            in_last = 1'(i); in_tag = 4'(8 + i);
            sample();
            check("frz_fill_ready", in_ready, 1'b1);
        end
        tick();
        in_valid = 1'b1; in_key = {16{8'h82}}; in_last = 1'b0; in_tag = 4'ha;
        sys_en = 1'b0; out_ready = 1'b1;
        sample();
        for (int i = 0; i < 5; i++) begin
            check("frz_in_ready", in_ready, 1'b0);
            check("frz_valid", out_valid, 1'b1);
            check("frz_tag", out_tag, 4'h8);
            check("frz_state", out_state, ref_round(s_fix, {16{8'h80}}, 1'b0));
            if (i < 4) begin
                tick();
                sample();
            end
        end
        tick();
        sys_en = 1'b1;
        sample();
        check("frz_resume_ready", in_ready, 1'b1);
        check("frz_resume_tag8", out_tag, 4'h8);
        tick();
        in_valid = 1'b0;
        sample();
        check("frz_tag9", out_tag, 4'h9);
        check("frz_last9", out_last, 1'b1);
        check("frz_state9", out_state, ref_round(s_fix, {16{8'h81}}, 1'b1));
        tick();
        sample();
        check("frz_tag10", out_tag, 4'ha);
        check("frz_state10", out_state, ref_round(s_fix, {16{8'h82}}, 1'b0));
        tick();
        sample();
        check("frz_empty", out_valid, 1'b0);

        // ---- reset pulse with 2 beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            in_valid = 1'b1; in_state = s_fix; in_key = '0; in_last = 1'b1; in_tag = 4'(1 + i);
            sample();
        end
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        sample();
        check("mrst_in_ready", in_ready, 1'b0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        sample();
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_state", out_state, 128'h0);
        check("mrst_tag", out_tag, 4'h0);
        check("mrst_in_ready1", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            check("mrst_no_output", out_valid, 1'b0);
        end

        // ---- random valid/ready, 1000 beats against the model
        sent = 0; recv = 0; cycles = 0; hold = 1'b0; h_state = '0; h_tag = '0;
        while (recv < 1000 && cycles < 20000) begin
            tick();
            in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_last  = 1'($urandom_range(0, 1));
            in_tag   = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            sample();
            if (hold) begin
                check("rnd_hold_valid", out_valid, 1'b1);
                check("rnd_hold_state", out_state, h_state);
                check("rnd_hold_tag", out_tag, h_tag);
            end
            if (in_valid && in_ready) begin
                e.st = ref_round(in_state, in_key, in_last);
                e.tag = in_tag;
                e.last = in_last;
                sb_q.push_back(e);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rnd_spurious_out", out_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("rnd_state", out_state, e.st);
                    check("rnd_tag", out_tag, e.tag);
                    check("rnd_last", out_last, e.last);
                end
                recv++;
            end
            hold    = out_valid && !out_ready;
            h_state = out_state;
            h_tag   = out_tag;
            cycles++;
        end
        check("rnd_received", recv, 1000);
        check("rnd_queue_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
